sobel_square_module: RTL and testbench

- Computes the Sobel squared gradient magnitude, Gx^2 + Gy^2, for a grayscale pixel stream.
- Its squareModule/deOut outputs feed the modulus (square-root) stage directly.
- Holds two line buffers that form a 3x3 window, followed by a fixed-latency arithmetic pipeline.
- Video sync signals are delayed to stay aligned with the output data.

---
 rtl/sobel_square_module.sv | 169 ++++++++++++++++
 tb/tb_sobel_square_module.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sobel_square_module.sv
// Sobel squared gradient magnitude (Gx'^2 + Gy'^2) over a streamed 3x3 window, fixed 4-cycle latency.
// Build option SOBEL_SATURATE_EN: scale gradients by >>>1 with saturation to +/-255 instead of >>>2.
module sobel_square_module #(
    parameter int IMG_WIDTH = 1280,
    parameter int PIPE_LAT  = 4
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [7:0]  pixelIn,
    input  logic        de,
    input  logic        hsync,
    input  logic        vsync,
    output logic [16:0] squareModule,
    output logic        deOut,
    output logic        hsyncOut,
    output logic        vsyncOut
);

    localparam int CW = $clog2(IMG_WIDTH + 1);
    localparam int AW = $clog2(IMG_WIDTH);
    localparam logic [CW-1:0] COL_SAT = CW'(IMG_WIDTH);

    logic                     de_prev_q, de_prev_d;
    logic                     vs_prev_q, vs_prev_d;
    logic [CW-1:0]            col_q, col_d;
    logic [1:0]               row_q, row_d;
    logic [2:0][2:0][7:0]     win_q, win_d;
    logic                     v1_q, v1_d;
    logic signed [8:0]        gx_q, gx_d, gy_q, gy_d;
    logic                     v2_q, v2_d;
    logic [15:0]              sqx_q, sqx_d, sqy_q, sqy_d;
    logic                     v3_q, v3_d;
    logic [16:0]              sum_q, sum_d;
    logic [PIPE_LAT-1:0][2:0] sync_q, sync_d;

    logic [7:0] lb0_mem [IMG_WIDTH];
    logic [7:0] lb1_mem [IMG_WIDTH];

    logic          de_rise, de_fall, vs_rise, beyond;
    logic [CW-1:0] col_cur;
    logic [AW-1:0] rd_addr;
    logic [7:0]    lb0_rd, lb1_rd;
    logic signed [10:0] gx_full, gy_full;

    function automatic logic signed [10:0] ext(input logic [7:0] v);
        return signed'({3'b000, v});
    endfunction

    function automatic logic signed [8:0] scale(input logic signed [10:0] g);
`ifdef SOBEL_SATURATE_EN
        logic signed [10:0] h;
        h = g >>> 1;
        if (h > 11'sd255)
            return 9'sd255;
        else if (h < -11'sd255)
            return -9'sd255;
        else
            return h[8:0];
`else
        return 9'(g >>> 2);
`endif
    endfunction

    // |g| always fits 8 bits after scaling, so square the magnitude unsigned.
    function automatic logic [15:0] square(input logic signed [8:0] g);
        logic [7:0] a;
        a = g[8] ? 8'(-g) : 8'(g);
        return {8'b0, a} * {8'b0, a};
    endfunction

    always_comb begin
        de_rise = de & ~de_prev_q;
        de_fall = ~de & de_prev_q;
        vs_rise = vsync & ~vs_prev_q;
        col_cur = de_rise ? '0 : col_q;
        beyond  = (col_cur == COL_SAT);
        rd_addr = beyond ? AW'(IMG_WIDTH - 1) : col_cur[AW-1:0];
        lb0_rd  = lb0_mem[rd_addr];
        lb1_rd  = lb1_mem[rd_addr];
    end

    always_comb begin
        de_prev_d = de;
        vs_prev_d = vsync;
        col_d     = col_q;
        row_d     = row_q;
        win_d     = win_q;
        v1_d      = de && (row_q == 2'd2) && (col_cur >= CW'(2)) && !beyond;

        if (de)
            col_d = beyond ? col_cur : col_cur + CW'(1);

        if (vs_rise)
            row_d = 2'd0;
        else if (de_fall && row_q != 2'd2)
            row_d = row_q + 2'd1;

        if (de) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = pixelIn;
        end
    end

    always_comb begin
        gx_full = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
                - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
        gy_full = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
                - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
        gx_d   = scale(gx_full);
        gy_d   = scale(gy_full);
        v2_d   = v1_q;
        sqx_d  = square(gx_q);
        sqy_d  = square(gy_q);
        v3_d   = v2_q;
        sum_d  = v3_q ? ({1'b0, sqx_q} + {1'b0, sqy_q}) : '0;
        sync_d = {sync_q[PIPE_LAT-2:0], {de, hsync, vsync}};
    end

    // Line buffers are plain RAM: never reset, read-before-write on the same address.
    always_ff @(posedge pclk) begin
        if (de && !beyond) begin
            lb0_mem[rd_addr] <= pixelIn;
            lb1_mem[rd_addr] <= lb0_rd;
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            de_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            win_q     <= '0;
            v1_q      <= 1'b0;
            gx_q      <= '0;
            gy_q      <= '0;
            v2_q      <= 1'b0;
            sqx_q     <= '0;
            sqy_q     <= '0;
            v3_q      <= 1'b0;
            sum_q     <= '0;
            sync_q    <= '0;
        end else begin
            de_prev_q <= de_prev_d;
            vs_prev_q <= vs_prev_d;
            col_q     <= col_d;
            row_q     <= row_d;
            win_q     <= win_d;
            v1_q      <= v1_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            v2_q      <= v2_d;
            sqx_q     <= sqx_d;
            sqy_q     <= sqy_d;
            v3_q      <= v3_d;
            sum_q     <= sum_d;
            sync_q    <= sync_d;
        end
    end

    assign squareModule = sum_q;
    assign {deOut, hsyncOut, vsyncOut} = sync_q[PIPE_LAT-1];

endmodule

// File: tb/tb_sobel_square_module.sv
// Bench for sobel_square_module: frame-level image model compared every cycle, plus literal anchors.
module tb_sobel_square_module;
    localparam int W = 16;
    localparam int DEPTH = 16384;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pixelIn = '0;
    logic        de = 1'b0, hsync = 1'b0, vsync = 1'b0;
    logic [16:0] squareModule;
    logic        deOut, hsyncOut, vsyncOut;

    sobel_square_module #(.IMG_WIDTH(W), .PIPE_LAT(4)) dut (
        .pclk(pclk), .reset(reset), .pixelIn(pixelIn), .de(de), .hsync(hsync), .vsync(vsync),
        .squareModule(squareModule), .deOut(deOut), .hsyncOut(hsyncOut), .vsyncOut(vsyncOut)
    );

    always #5 pclk = ~pclk;

    int total = 0, bad = 0;
    int n = 0;
    int exp_sq [DEPTH];
    bit exp_de [DEPTH], exp_hs [DEPTH], exp_vs [DEPTH];
    int img [0:9][0:23];
    int nz_cnt = 0, nz_sum = 0;

`ifdef SOBEL_SATURATE_EN
    localparam int EDGE200 = 65025;
    localparam int EDGE100 = 40000;
`else
    localparam int EDGE200 = 40000;
    localparam int EDGE100 = 10000;
`endif

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    function automatic int scale(input int g);
`ifdef SOBEL_SATURATE_EN
        int h;
        h = fdiv(g, 2);
        if (h > 255) h = 255;
        if (h < -255) h = -255;
        return h;
`else
        return fdiv(g, 4);
`endif
    endfunction

    // p[row][col], row 0 = oldest line, col 2 = newest pixel
    function automatic int model_win(input int p [3][3]);
        int gx, gy;
        gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
        gx = scale(gx);
        gy = scale(gy);
        return gx*gx + gy*gy;
    endfunction

    function automatic int model_at(input int r, input int c);
        int p [3][3];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = img[r-2+i][c-2+j];
        return model_win(p);
    endfunction

    task automatic step(input int pix, input bit d, input bit h, input bit v, input int r, input int c);
        @(negedge pclk);
        pixelIn = pix[7:0];
        de = d; hsync = h; vsync = v;
        exp_de[n] = d; exp_hs[n] = h; exp_vs[n] = v;
        exp_sq[n] = (d && r >= 2 && c >= 2 && c < W) ? model_at(r, c) : 0;
        n++;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset mid-stream: everything in flight is flushed to zero.
    task automatic do_reset();
        @(negedge pclk);
        reset = 1'b1;
        pixelIn = '0; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
        for (int k = n - 3; k < n; k++)
            if (k >= 0) begin
                exp_sq[k] = 0; exp_de[k] = 0; exp_hs[k] = 0; exp_vs[k] = 0;
            end
        exp_sq[n] = 0; exp_de[n] = 0; exp_hs[n] = 0; exp_vs[n] = 0;
        n++;
        #1;
        check("rst_immediate", int'({squareModule, deOut, hsyncOut, vsyncOut}), 0);
        idle(2);
        reset = 1'b0;
    endtask

    // pat: 0 flat, 1 vstep, 2 reversed vstep, 3 hstep 0->100, 4 hstep 0->255, 5 random
    task automatic run_frame(input int pat, input int nlines, input int len_fix, input int abort_line);
        int len, nb;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 24; c++)
                case (pat)
                    0: img[r][c] = 100;
                    1: img[r][c] = (c < 8) ? 0 : 200;
                    2: img[r][c] = (c < 8) ? 200 : 0;
                    3: img[r][c] = (r < 5) ? 0 : 100;
                    4: img[r][c] = (r < 5) ? 0 : 255;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(2);
        for (int r = 0; r < nlines; r++) begin
            nb  = (len_fix == 0) ? int'($urandom_range(2, 5)) : 3;
            len = (len_fix == 0) ? int'($urandom_range(W, W + 4)) : len_fix;
            for (int b = 0; b < nb; b++) step(0, 0, (b < 2), 0, r, 0);
            for (int c = 0; c < len; c++) begin
                if (r == abort_line && c == len / 2) begin
                    do_reset();
                    return;
                end
                step(img[r][c], 1, 0, 0, r, c);
            end
        end
        idle(8);
    endtask

    always @(posedge pclk) begin
        #1;
        if (n >= 4) begin
            check("square", int'(squareModule), exp_sq[n-4]);
            check("sync", int'({deOut, hsyncOut, vsyncOut}),
                  int'({exp_de[n-4], exp_hs[n-4], exp_vs[n-4]}));
            if (squareModule != 0) begin
                nz_cnt++;
                nz_sum += int'(squareModule);
            end
        end
    end

    task automatic directed(input string name, input int pat, input int nlines, input int len,
                            input int want_cnt, input int want_val);
        nz_cnt = 0; nz_sum = 0;
        run_frame(pat, nlines, len, -1);
        check({name, "_hits"}, nz_cnt, want_cnt);
        check({name, "_sum"}, nz_sum, want_cnt * want_val);
    endtask

    initial begin
        int w [3][3];
        w = '{'{0, 0, 200}, '{0, 0, 200}, '{0, 0, 200}};
        check("model_vstep", model_win(w), EDGE200);
        w = '{'{200, 200, 0}, '{200, 200, 0}, '{200, 200, 0}};
        check("model_revstep", model_win(w), EDGE200);
        w = '{'{0, 0, 0}, '{0, 0, 0}, '{100, 100, 100}};
        check("model_hstep", model_win(w), EDGE100);
        w = '{'{1, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
        check("model_floor_shift", model_win(w), 2);
        w = '{'{0, 0, 0}, '{0, 0, 0}, '{255, 255, 255}};
        check("model_max", model_win(w), 65025);

        idle(4);
        #1;
        check("reset_state", int'({squareModule, deOut, hsyncOut, vsyncOut}), 0);
        reset = 1'b0;

        directed("flat", 0, 6, W, 0, 0);
        directed("vstep", 1, 6, W, 8, EDGE200);
        directed("revstep", 2, 6, W, 8, EDGE200);
        directed("hstep", 3, 8, W, 28, EDGE100);
        directed("hstep255", 4, 8, W, 28, 65025);
        directed("longline", 1, 6, 20, 8, EDGE200);

        run_frame(1, 6, W, 3);
        idle(6);
        directed("flat_after_rst", 0, 6, W, 0, 0);
        directed("vstep_after_rst", 1, 6, W, 8, EDGE200);

        for (int f = 0; f < 4; f++)
            run_frame(5, int'($urandom_range(4, 8)), 0, -1);
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
